alu_secuenciador_muldiv: RTL
============================

Name: alu_secuenciador_muldiv

Overview:
- Multi-cycle controller that runs unsigned multiply and unsigned divide on the shared N-bit ripple ALU (ALUNBits).
- Issues one ALU add or subtract per cycle and keeps the partial product, or the remainder and quotient, in internal registers.
- Sits beside the single-cycle datapath; the control unit raises start_i for MULTU/DIVU-class instructions and stalls on busy_o.

Parameters:
- N, 8, operand width; must match the ALU instance width; N >= 2.
- CNT_W, $clog2(N)+1, iteration counter width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE.
- div_i  input  1  0 = multiply, 1 = divide; sampled with start_i.
- a_i  input  N  multiplicand / dividend.
- b_i  input  N  multiplier / divisor.
- alu_a_o  output  N  ALU operand A.
- alu_b_o  output  N  ALU operand B.
- alu_op_o  output  4  ALU operation code.
- alu_c_o  output  1  ALU carry-in.
- alu_invert_o  output  1  ALU B-invert.
- alu_res_i  input  N  ALU result (combinational).
- alu_c_i  input  1  ALU carry-out (combinational).
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle completion pulse.
- div0_o  output  1  divide-by-zero flag for the last operation.
- hi_o  output  N  product high half / remainder.
- lo_o  output  N  product low half / quotient.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy_o=0, done_o=0, div0_o=0, hi_o=0, lo_o=0; counter=0; ALU drive outputs=0.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start_i=1 and div_i=0: latch a_i into M; HI=0, LO=b_i; counter=N; go to MUL.
  - start_i=1, div_i=1, b_i!=0: latch D=b_i; R=0, Q=a_i; counter=N; go to DIV.
  - start_i=1, div_i=1, b_i==0: HI=a_i, LO=all ones, div0_o=1; go to FIN with no iterations.
  - Every accepted start clears div0_o unless the divide-by-zero case sets it.
- MUL, one iteration per cycle:
  - ALU drives alu_a_o=HI, alu_b_o = LO[0] ? M : 0, op=ADD (alu_op_o=4'b0010, alu_invert_o=0, alu_c_o=0).
  - Next state of {HI,LO} = {alu_c_i, alu_res_i, LO} >> 1.
  - Decrement counter; at counter==1 go to FIN.
- DIV, restoring, one iteration per cycle:
  - Form {msb, S, Qs} = {R, Q} << 1.
  - ALU drives alu_a_o=S, alu_b_o=D, op=SUB (alu_op_o=4'b0010, alu_invert_o=1, alu_c_o=1).
  - ok = msb | alu_c_i. If ok: R=alu_res_i, Q={Qs[N-1:1],1}. Otherwise: R=S, Q={Qs[N-1:1],0}.
  - Decrement counter; at counter==1 go to FIN.
- FIN: done_o=1 for exactly one cycle; hi_o/lo_o load from HI/LO (MUL) or R/Q (DIV); go to IDLE.
- Latency: start edge at cycle t gives done_o high in cycle t+N+1. For divide-by-zero, done_o is high in cycle t+1.
- busy_o is high from t+1 through the FIN cycle inclusive. It is low in IDLE.
- hi_o, lo_o and div0_o hold their values until the next FIN or reset. They never show intermediate values.
- start_i while not in IDLE is ignored; no queueing.
- In IDLE the ALU drive outputs are 0; the shared ALU mux gives the datapath the ALU whenever busy_o=0.
- All arithmetic is mod 2^N per ALU pass. The product is exact in 2N bits; the carry is captured through alu_c_i.

Decomposition:
- Package alu_pkg holds:
  - ALU_OP_ADD=4'b0010, ALU_OP_SUB=4'b0010 with INV=1/CIN=1, ALU_OP_SLL=4'b1001, ALU_OP_SRL=4'b1010, ALU_OP_SRA=4'b1011.
  - State encoding: ST_IDLE=2'd0, ST_MUL=2'd1, ST_DIV=2'd2, ST_FIN=2'd3.
- The controller contains no ALU.
- One wrapper sub-module, muldiv_unidad, instantiates ALUNBits (N) and alu_secuenciador_muldiv for standalone test.

Test Plan:
- N=8, MUL 13*11: start at t -> done_o at t+9; hi_o=0x00, lo_o=0x8F; busy_o high t+1..t+9.
- MUL 0xFF*0xFF -> hi_o=0xFE, lo_o=0x01 (checks carry capture); then MUL 0*0x7F -> hi_o=0x00, lo_o=0x00.
- DIV 200/7 -> lo_o=0x1C, hi_o=0x04, div0_o=0; then DIV 0xFF/0x01 -> lo_o=0xFF, hi_o=0x00; then DIV 0x80/0xFF -> lo_o=0x00, hi_o=0x80.
- DIV 0x25/0 -> done_o at t+1; div0_o=1, lo_o=0xFF, hi_o=0x25; next valid MUL clears div0_o.
- Pulse start_i again mid-MUL -> ignored; result and done timing unchanged; after done_o, back-to-back start in the following IDLE cycle is accepted.
- Assert rst_i asynchronously mid-DIV (iteration 4) -> all outputs 0 immediately, state IDLE, no done_o; fresh DIV completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, ALU control bundle and multiply/divide sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_OP_AND = 4'b0000;
    localparam logic [3:0] ALU_OP_OR  = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0010;  // with invert=1, carry-in=1
    localparam logic [3:0] ALU_OP_SLL = 4'b1001;
    localparam logic [3:0] ALU_OP_SRL = 4'b1010;
    localparam logic [3:0] ALU_OP_SRA = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic       invert;
        logic       cin;
    } alu_ctl_t;

    localparam alu_ctl_t ALU_CTL_NONE = '{op: 4'b0000,    invert: 1'b0, cin: 1'b0};
    localparam alu_ctl_t ALU_CTL_ADD  = '{op: ALU_OP_ADD, invert: 1'b0, cin: 1'b0};
    localparam alu_ctl_t ALU_CTL_SUB  = '{op: ALU_OP_SUB, invert: 1'b1, cin: 1'b1};

endpackage

// File: rtl/ALUNBits.sv
// N-bit combinational ALU: AND/OR, add/subtract via B-invert and carry-in, logical/arithmetic shifts.
module ALUNBits
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [3:0]   op_i,
    input  logic         c_i,
    input  logic         invert_i,
    output logic [N-1:0] res_o,
    output logic         c_o
);

    localparam int unsigned SH_W = $clog2(N);

    logic [N-1:0]    b_eff;
    logic [N:0]      sum;
    logic [SH_W-1:0] shamt;

    always_comb begin
        b_eff = invert_i ? ~b_i : b_i;
        sum   = {1'b0, a_i} + {1'b0, b_eff} + (N+1)'(c_i);
        shamt = b_i[SH_W-1:0];
        res_o = '0;
        c_o   = 1'b0;
        case (op_i)
            ALU_OP_AND: res_o = a_i & b_eff;
            ALU_OP_OR:  res_o = a_i | b_eff;
            ALU_OP_ADD: begin
                res_o = sum[N-1:0];
                c_o   = sum[N];
            end
            ALU_OP_SLL: res_o = a_i << shamt;
            ALU_OP_SRL: res_o = a_i >> shamt;
            ALU_OP_SRA: res_o = $unsigned($signed(a_i) >>> shamt);
            default:    res_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unidad.sv
// Standalone multiply/divide unit: sequencer paired with its own N-bit ALU.
module muldiv_unidad
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         div_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         div0_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o
);

    logic [N-1:0] alu_a, alu_b, alu_res;
    logic [3:0]   alu_op;
    logic         alu_cin, alu_inv, alu_cout;

    ALUNBits #(.N(N)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .c_i      (alu_cin),
        .invert_i (alu_inv),
        .res_o    (alu_res),
        .c_o      (alu_cout)
    );

    alu_secuenciador_muldiv #(.N(N)) u_seq (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .div_i        (div_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_c_o      (alu_cin),
        .alu_invert_o (alu_inv),
        .alu_res_i    (alu_res),
        .alu_c_i      (alu_cout),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .div0_o       (div0_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

endmodule

// File: rtl/alu_secuenciador_muldiv.sv
// Multi-cycle unsigned multiply / restoring divide controller driving an external shared ALU,
// one add or subtract per cycle; ALU drive outputs are registered from the next-cycle state.
module alu_secuenciador_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = $clog2(N) + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         div_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [3:0]   alu_op_o,
    output logic         alu_c_o,
    output logic         alu_invert_o,
    input  logic [N-1:0] alu_res_i,
    input  logic         alu_c_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         div0_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o
);

    state_e             state_q, state_d;
    logic [N-1:0]       hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d, div0_q, div0_d;
    logic [N-1:0]       hi_o_q, hi_o_d, lo_o_q, lo_o_d;
    logic [N-1:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    alu_ctl_t           alu_ctl_q, alu_ctl_d;

    logic [N-1:0]       s_cur, qs_cur, s_nxt;
    logic               ok;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        div0_d    = div0_q;
        hi_o_d    = hi_o_q;
        lo_o_d    = lo_o_q;
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_ctl_d = ALU_CTL_NONE;

        // {R,Q} << 1 split into the dropped msb, the new partial remainder S and shifted quotient
        s_cur  = {hi_q[N-2:0], lo_q[N-1]};
        qs_cur = {lo_q[N-2:0], 1'b0};
        ok     = hi_q[N-1] | alu_c_i;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cnt_d = CNT_W'(N);
                    hi_d  = '0;
                    if (!div_i) begin
                        opnd_d  = a_i;
                        lo_d    = b_i;
                        state_d = ST_MUL;
                    end else if (b_i != '0) begin
                        opnd_d  = b_i;
                        lo_d    = a_i;
                        state_d = ST_DIV;
                    end else begin
                        cnt_d   = '0;
                        hi_o_d  = a_i;
                        lo_o_d  = '1;
                        div0_d  = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_MUL: begin
                {hi_d, lo_d} = {alu_c_i, alu_res_i, lo_q[N-1:1]};
                cnt_d        = cnt_q - CNT_W'(1);
            end
            ST_DIV: begin
                hi_d  = ok ? alu_res_i : s_cur;
                lo_d  = {qs_cur[N-1:1], ok};
                cnt_d = cnt_q - CNT_W'(1);
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // last iteration publishes the result together with the FIN transition
        if ((state_q == ST_MUL || state_q == ST_DIV) && cnt_q == CNT_W'(1)) begin
            state_d = ST_FIN;
            hi_o_d  = hi_d;
            lo_o_d  = lo_d;
            div0_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
        s_nxt  = {hi_d[N-2:0], lo_d[N-1]};

        case (state_d)
            ST_MUL: begin
                alu_a_d   = hi_d;
                alu_b_d   = lo_d[0] ? opnd_d : '0;
                alu_ctl_d = ALU_CTL_ADD;
            end
            ST_DIV: begin
                alu_a_d   = s_nxt;
                alu_b_d   = opnd_d;
                alu_ctl_d = ALU_CTL_SUB;
            end
            default: alu_ctl_d = ALU_CTL_NONE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            hi_o_q    <= '0;
            lo_o_q    <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_ctl_q <= ALU_CTL_NONE;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
            hi_o_q    <= hi_o_d;
            lo_o_q    <= lo_o_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_ctl_q <= alu_ctl_d;
        end
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_ctl_q.op;
    assign alu_invert_o = alu_ctl_q.invert;
    assign alu_c_o      = alu_ctl_q.cin;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign div0_o       = div0_q;
    assign hi_o         = hi_o_q;
    assign lo_o         = lo_o_q;

endmodule
